fpga_watchdog: RTL

Watchdog timer that generates a system reset request, driving the active-low `force_rst_n` input of the two-stage power-on reset generator. Software arms it, then must kick it periodically. If the countdown reaches zero without a kick, or software forces a reset, the block pulls its reset-request output low for a fixed number of cycles. A sticky expiry flag survives the resulting system reset, so boot code can tell a watchdog reboot from a cold start. The block's own `rst` must come from a domain that `rst_req_n` does not reset, e.g. power-on only.

---
 rtl/fpga_watchdog_if.sv | 26 ++
 rtl/fpga_watchdog.sv | 131 +++++++++++++
 2 files changed

// File: rtl/fpga_watchdog_if.sv
// Control/status bundle between software-facing logic and the watchdog.
// The reset strobe is named force_req because "force" is a reserved SystemVerilog keyword.
interface fpga_watchdog_if #(
    parameter int W_CTR = 24
);
    logic             en;
    logic [W_CTR-1:0] reload;
    logic             kick;
    logic             force_req;
    logic             clear_expired;
    logic             rst_req_n;
    logic             expired;
    logic             running;
    logic [W_CTR-1:0] count;
    logic [1:0]       state;

    modport master (
        output en, reload, kick, force_req, clear_expired,
        input  rst_req_n, expired, running, count, state
    );

    modport slave (
        input  en, reload, kick, force_req, clear_expired,
        output rst_req_n, expired, running, count, state
    );
endinterface

// File: rtl/fpga_watchdog.sv
// Watchdog timer: countdown armed by en, restarted by kick, firing a PULSE-cycle
// active-low reset request on timeout or force. expired is sticky across that reset.
module fpga_watchdog #(
    parameter int W_CTR = 24,
    parameter int PULSE = 16
) (
    input logic            clk,
    input logic            rst,
    fpga_watchdog_if.slave wd
);
    localparam int W_PLS = $clog2(PULSE + 1);
    localparam logic [W_PLS-1:0] PLS_LOAD = W_PLS'(PULSE);
    localparam logic [W_PLS-1:0] PLS_LAST = W_PLS'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIRE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [W_CTR-1:0] count_q, count_d;
    logic [W_PLS-1:0] pls_q, pls_d;
    logic             rst_req_n_q, rst_req_n_d;
    logic             expired_q, expired_d;
    logic             running_q, running_d;
    logic             expire_set;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        pls_d       = pls_q;
        rst_req_n_d = rst_req_n_q;
        running_d   = running_q;
        expire_set  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (wd.force_req) begin
                    state_d     = ST_FIRE;
                    pls_d       = PLS_LOAD;
                    rst_req_n_d = 1'b0;
                    running_d   = 1'b0;
                end else if (wd.en) begin
                    state_d   = ST_RUN;
                    count_d   = wd.reload;
                    running_d = 1'b1;
                end
            end

            ST_RUN: begin
                if (wd.force_req) begin
                    state_d     = ST_FIRE;
                    pls_d       = PLS_LOAD;
                    rst_req_n_d = 1'b0;
                    running_d   = 1'b0;
                end else if (!wd.en) begin
                    state_d   = ST_IDLE;
                    running_d = 1'b0;
                end else if (wd.kick) begin
                    // A kick still rescues the countdown on the cycle it hits zero.
                    count_d = wd.reload;
                end else if (count_q != '0) begin
                    count_d = count_q - W_CTR'(1);
                end else begin
                    state_d     = ST_FIRE;
                    pls_d       = PLS_LOAD;
                    rst_req_n_d = 1'b0;
                    running_d   = 1'b0;
                    expire_set  = 1'b1;
                end
            end

            ST_FIRE: begin
                // pls_q holds the low cycles still owed, including the current one.
                if (pls_q == PLS_LAST) begin
                    state_d     = ST_IDLE;
                    rst_req_n_d = 1'b1;
                    count_d     = '0;
                end else begin
                    pls_d = pls_q - PLS_LAST;
                end
            end

            default: begin
                state_d     = ST_IDLE;
                rst_req_n_d = 1'b1;
                running_d   = 1'b0;
            end
        endcase

        if (expire_set) begin
            expired_d = 1'b1;
        end else if (wd.clear_expired) begin
            expired_d = 1'b0;
        end else begin
            expired_d = expired_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            pls_q       <= '0;
            rst_req_n_q <= 1'b1;
            expired_q   <= 1'b0;
            running_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            pls_q       <= pls_d;
            rst_req_n_q <= rst_req_n_d;
            expired_q   <= expired_d;
            running_q   <= running_d;
        end
    end

    assign wd.rst_req_n = rst_req_n_q;
    assign wd.expired   = expired_q;
    assign wd.running   = running_q;
    assign wd.count     = count_q;
    assign wd.state     = state_q;

    a_run_no_req: assert property (@(posedge clk) disable iff (rst)
        running_q |-> rst_req_n_q);
    a_fire_is_req: assert property (@(posedge clk) disable iff (rst)
        (state_q == ST_FIRE) == !rst_req_n_q);
    a_running_is_run: assert property (@(posedge clk) disable iff (rst)
        running_q == (state_q == ST_RUN));
endmodule
